// File: rtl/gcd_euclid.sv
// Multi-cycle Euclid GCD engine using a bit-serial restoring remainder.
// Optional GCD_ITER_COUNT_EN adds an 8-bit iteration counter output.
module gcd_euclid #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd,
    output logic             err
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [7:0]       iter_cnt
`endif
);

    localparam int NW = $clog2(WIDTH + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_DIV   = 3'd2;
    localparam logic [2:0] S_SWAP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [NW-1:0]    n;
    logic [WIDTH:0]   diff;

    // Trial subtract of the divisor from the shifted partial remainder
    assign diff = {r, q[WIDTH-1]} - {1'b0, rb};

    assign ready = (state == S_IDLE);
    assign busy  = (state == S_CHECK) || (state == S_DIV)
                || (state == S_SWAP);
    assign done  = (state == S_DONE);

`ifdef GCD_ITER_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            iter_cnt <= '0;
        end else if (state == S_SWAP && iter_cnt != 8'hff) begin
            iter_cnt <= iter_cnt + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ra    <= '0;
            rb    <= '0;
            r     <= '0;
            q     <= '0;
            n     <= '0;
            gcd   <= '0;
            err   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        gcd   <= '0;
                        err   <= 1'b0;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (rb == '0) begin
                        gcd   <= ra;
                        err   <= (ra == '0);
                        state <= S_DONE;
                    end else begin
                        r     <= '0;
                        q     <= ra;
                        n     <= NW'(WIDTH);
                        state <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (diff[WIDTH]) begin
                        r <= {r[WIDTH-2:0], q[WIDTH-1]};
                        q <= {q[WIDTH-2:0], 1'b0};
                    end else begin
                        r <= diff[WIDTH-1:0];
                        q <= {q[WIDTH-2:0], 1'b1};
                    end
                    n <= n - NW'(1);
                    if (n == NW'(1)) begin
                        state <= S_SWAP;
                    end
                end
                S_SWAP: begin
                    ra    <= rb;
                    rb    <= r;
                    state <= S_CHECK;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_euclid.sv
// Self-checking bench for gcd_euclid: directed table, corner
// sequences and random operands against a plain-arithmetic model.
module tb_gcd_euclid;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] gcd;
    logic         err;
`ifdef GCD_ITER_COUNT_EN
    logic [7:0]   iter_cnt;
`endif

    int checks;
    int failures;

    gcd_euclid #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .a(a),
        .b(b),
        .ready(ready),
        .busy(busy),
        .done(done),
        .gcd(gcd),
        .err(err)
`ifdef GCD_ITER_COUNT_EN
        ,
        .iter_cnt(iter_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] g;
        logic         e;
        int           lat;
    } vec_t;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Euclid with plain %, counting mod iterations
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         output logic [W-1:0] mg, output logic me,
                         output int mk);
        int x;
        int y;
        int t;
        x  = int'(ma);
        y  = int'(mb);
        mk = 0;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
            mk++;
        end
        mg = W'(x);
        me = (ma == '0) && (mb == '0);
    endtask

    task automatic run_job(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic [W-1:0] eg, input logic ee,
                           input int elat, input int poke,
                           input string name);
        int got;
        int waitc;
        int eiter;
        waitc = 0;
        @(negedge clk);
        while (!ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!ready) chk({name, " ready_timeout"}, 0, 1);
        a     = ta;
        b     = tb;
        start = 1'b1;
        @(posedge clk);
        got = -1;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (c == poke) begin
                start = 1'b1;
                a     = 16'd100;
                b     = 16'd75;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                got = c;
                break;
            end
        end
        chk({name, " latency"}, got, elat);
        chk({name, " gcd"}, gcd, eg);
        chk({name, " err"}, err, ee);
        eiter = (elat - 2) / (W + 2);
        if (eiter > 255) eiter = 255;
`ifdef GCD_ITER_COUNT_EN
        chk({name, " iter_cnt"}, iter_cnt, eiter);
`endif
        @(negedge clk);
        start = 1'b0;
        chk({name, " done_pulse"}, done, 0);
        chk({name, " idle_after"}, {ready, busy}, 2'b10);
        chk({name, " gcd_held"}, gcd, eg);
    endtask

    task automatic run_rand(input logic [W-1:0] ra, input logic [W-1:0] rb,
                            input string name);
        logic [W-1:0] mg;
        logic         me;
        int           mk;
        model(ra, rb, mg, me, mk);
        run_job(ra, rb, mg, me, (W + 2) * mk + 2, -1, name);
    endtask

    vec_t vecs[7];

    initial begin
        checks   = 0;
        failures = 0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        rst_n    = 1'b0;

        vecs[0] = '{16'd48,    16'd18,    16'd6,  1'b0, 56};
        vecs[1] = '{16'd18,    16'd48,    16'd6,  1'b0, 74};
        vecs[2] = '{16'd17,    16'd0,     16'd17, 1'b0, 2};
        vecs[3] = '{16'd0,     16'd5,     16'd5,  1'b0, 20};
        vecs[4] = '{16'd0,     16'd0,     16'd0,  1'b1, 2};
        vecs[5] = '{16'd65535, 16'd65534, 16'd1,  1'b0, 38};
        vecs[6] = '{16'd100,   16'd75,    16'd25, 1'b0, 38};

        repeat (3) @(negedge clk);
        chk("reset ready_busy", {ready, busy}, 2'b10);
        chk("reset done", done, 0);
        chk("reset gcd", gcd, 0);
        chk("reset err", err, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_job(vecs[i].a, vecs[i].b, vecs[i].g, vecs[i].e,
                    vecs[i].lat, -1, $sformatf("vec%0d", i));
        end

        // Start during DIV is ignored; start during DONE is ignored
        run_job(16'd48, 16'd18, 16'd6, 1'b0, 56, 5, "start_in_div");
        run_job(16'd48, 16'd18, 16'd6, 1'b0, 56, 56, "start_in_done");
        run_job(16'd100, 16'd75, 16'd25, 1'b0, 38, -1, "after_ignore");

        // Busy while running
        @(negedge clk);
        a     = 16'd48;
        b     = 16'd18;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_check", {ready, busy}, 2'b01);
        repeat (4) @(negedge clk);
        chk("busy_div", {ready, busy, done}, 3'b010);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst ready", ready, 1);
        chk("async_rst busy", busy, 0);
        chk("async_rst done", done, 0);
        chk("async_rst gcd", gcd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(16'd12, 16'd8, 16'd4, 1'b0, 38, -1, "after_reset");

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 4 == 1) rb = W'($urandom_range(0, 20));
            if (i % 4 == 2) begin
                ra = W'($urandom_range(1, 60) * 12);
                rb = W'($urandom_range(1, 60) * 12);
            end
            run_rand(ra, rb, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gcd_euclid.md
Name: gcd_euclid

Overview:
- Multi-cycle GCD engine that sits directly downstream of the 16-bit modulo datapath and consumes its remainder.
- Computes gcd(a,b) by Euclid's algorithm: (A,B) <= (B, A mod B) until B==0.
- Each mod step runs the same bit-serial restoring division, one remainder bit per cycle, plus a start/ready/done handshake.
- Feeds later number-theory stages with the result.

Parameters:
- WIDTH, 16, operand/result width in bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only on a rising edge where ready=1
- a  input  WIDTH  first operand, sampled on accept
- b  input  WIDTH  second operand, sampled on accept
- ready  output  1  high in IDLE only
- busy  output  1  high in CHECK, DIV or SWAP
- done  output  1  one-cycle pulse, high in DONE state
- gcd  output  WIDTH  registered result, held until the next accept
- err  output  1  registered; set when a==0 and b==0; held with gcd

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; gcd, err, done, internal RA/RB/R/Q/N cleared to 0; ready=1, busy=0 while idle.
- ready and busy decode from state. done is 1 exactly in DONE.
- IDLE:
  - start & ready: RA<=a, RB<=b, clear gcd/err, go CHECK.
  - Otherwise stay. start is ignored in every other state.
- CHECK:
  - If RB==0: gcd<=RA, err<=(RA==0), go DONE.
  - Else: R<=0, Q<=RA, N<=WIDTH, go DIV.
- DIV: one restoring step per cycle.
  - diff (WIDTH+1 bits) = {R,Q[MSB]} - {1'b0,RB}.
  - If diff[MSB]=1: {R,Q} <= {R,Q}<<1 with Q LSB 0.
  - Else: R<=diff[WIDTH-1:0], Q<={Q[WIDTH-2:0],1'b1}.
  - N<=N-1. After the step with N==1, go SWAP. DIV lasts exactly WIDTH cycles.
- SWAP: RA<=RB, RB<=R (remainder), go CHECK.
- DONE: one cycle, go IDLE. A start in this cycle is ignored (ready=0).
- Latency:
  - One Euclid iteration = CHECK + WIDTH DIV + SWAP = WIDTH+2 cycles (18 at default).
  - k = number of mod iterations.
  - done is high in cycle (WIDTH+2)*k+2 counted from the accepting edge. The cycle after the accepting edge is cycle 1.
- Boundary conditions:
  - a<b: first mod returns a, swap orders operands, costing one iteration.
  - b==0: gcd=a with k=0.
  - a==0, b!=0: k=1, gcd=b.
  - a==b==0: gcd=0, err=1.
- Reset mid-operation: aborts immediately, no done pulse, gcd=0.
- Quotient bits in Q are discarded; only R propagates.

Optional Feature:
- Macro: GCD_ITER_COUNT_EN.
- Defined:
  - Adds output port iter_cnt (8 bits).
  - Cleared on accept and on reset.
  - Increments once per SWAP; saturates at 255.
  - Valid, and held with gcd, from DONE onward.
- Undefined: port and counter absent. All other behaviour is identical.

Test Plan:
- a=48, b=18 -> k=3; done in cycle 56; gcd=6, err=0; iter_cnt=3.
- a=18, b=48 -> k=4; done in cycle 74; gcd=6; iter_cnt=4.
- a=17, b=0 -> done in cycle 2, gcd=17. Then a=0, b=5 -> done in cycle 20, gcd=5.
- a=0, b=0 -> done in cycle 2; gcd=0, err=1. a=65535, b=65534 -> k=2, gcd=1, done in cycle 38.
- Pulse start with a=100, b=75 during DIV of a running 48/18 job -> ignored; result still 6. Then start with a=100, b=75 -> gcd=25.
- Assert rst_n low mid-DIV -> gcd=0, done=0, ready=1 asynchronously, before the next clock edge. Release and run a=12, b=8 -> gcd=4.
